// File: rtl/qa_shim_tx_credit_pkg.sv
//------------------------------------------------------------------------------
// Module : qa_driver_types (package)
// Brief  : Shared types and error-bit indices for the QA Tx credit shim.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package qa_driver_types;

    localparam int QA_CCI_DATA_WIDTH   = 512;
    localparam int QA_CCI_TX_HDR_WIDTH = 61;

    typedef enum logic {
        QA_C1_WR = 1'b0,
        QA_C1_IR = 1'b1
    } t_qa_c1_req_kind;

    typedef struct packed {
        t_qa_c1_req_kind                  kind;
        logic [QA_CCI_TX_HDR_WIDTH-1:0]   hdr;
        logic [QA_CCI_DATA_WIDTH-1:0]     data;
    } t_qa_c1_tx_entry;

    localparam int ERR_FIFO_OVF   = 0;
    localparam int ERR_CREDIT_UNF = 1;
    localparam int ERR_C1_COLLIDE = 2;

endpackage

`default_nettype wire

// File: rtl/qa_shim_tx_credit_if.sv
//------------------------------------------------------------------------------
// Module : qa_shim_tx_credit_if
// Brief  : AFU/QLP CCI Tx bundle seen by the credit shim (stats ports when
//          QA_SHIM_TX_CREDIT_STATS_EN is defined).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface qa_shim_tx_credit_if #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_TX_HDR_WIDTH = 61
);
    logic [CCI_TX_HDR_WIDTH-1:0] afu_C0TxHdr;
    logic                        afu_C0TxRdValid;
    logic                        afu_C0TxAlmFull;
    logic [CCI_TX_HDR_WIDTH-1:0] afu_C1TxHdr;
    logic [CCI_DATA_WIDTH-1:0]   afu_C1TxData;
    logic                        afu_C1TxWrValid;
    logic                        afu_C1TxIrValid;
    logic                        afu_C1TxAlmFull;
    logic [CCI_TX_HDR_WIDTH-1:0] qlp_C0TxHdr;
    logic                        qlp_C0TxRdValid;
    logic                        qlp_C0TxAlmFull;
    logic [CCI_TX_HDR_WIDTH-1:0] qlp_C1TxHdr;
    logic [CCI_DATA_WIDTH-1:0]   qlp_C1TxData;
    logic                        qlp_C1TxWrValid;
    logic                        qlp_C1TxIrValid;
    logic                        qlp_C1TxAlmFull;
    logic                        qlp_C0RxRdValid;
    logic [2:0]                  err_sticky;
`ifdef QA_SHIM_TX_CREDIT_STATS_EN
    logic [31:0]                 stat_rd_issued;
    logic [31:0]                 stat_wr_issued;
    logic [31:0]                 stat_credit_stall_cycles;
`endif

    modport master (
        output afu_C0TxHdr, afu_C0TxRdValid, afu_C1TxHdr, afu_C1TxData,
               afu_C1TxWrValid, afu_C1TxIrValid, qlp_C0TxAlmFull,
               qlp_C1TxAlmFull, qlp_C0RxRdValid,
        input  afu_C0TxAlmFull, afu_C1TxAlmFull, qlp_C0TxHdr, qlp_C0TxRdValid,
               qlp_C1TxHdr, qlp_C1TxData, qlp_C1TxWrValid, qlp_C1TxIrValid,
`ifdef QA_SHIM_TX_CREDIT_STATS_EN
               stat_rd_issued, stat_wr_issued, stat_credit_stall_cycles,
`endif
               err_sticky
    );

    modport slave (
        input  afu_C0TxHdr, afu_C0TxRdValid, afu_C1TxHdr, afu_C1TxData,
               afu_C1TxWrValid, afu_C1TxIrValid, qlp_C0TxAlmFull,
               qlp_C1TxAlmFull, qlp_C0RxRdValid,
        output afu_C0TxAlmFull, afu_C1TxAlmFull, qlp_C0TxHdr, qlp_C0TxRdValid,
               qlp_C1TxHdr, qlp_C1TxData, qlp_C1TxWrValid, qlp_C1TxIrValid,
`ifdef QA_SHIM_TX_CREDIT_STATS_EN
               stat_rd_issued, stat_wr_issued, stat_credit_stall_cycles,
`endif
               err_sticky
    );

endinterface

`default_nettype wire

// File: rtl/qa_shim_tx_credit_fifo.sv
//------------------------------------------------------------------------------
// Module : qa_shim_fifo
// Brief  : Power-of-two FIFO with wrap-bit pointers and occupancy output.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module qa_shim_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       enq,
    input  wire logic [WIDTH-1:0]           enqData,
    input  wire logic                       deq,
    output logic      [WIDTH-1:0]           deqData,
    output logic                            notEmpty,
    output logic                            full,
    output logic      [$clog2(DEPTH):0]     occupancy
);
    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wrPtr;
    logic [c_ADDR_W:0] r_rdPtr;
    logic              w_push;
    logic              w_pop;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign full      = (r_wrPtr[c_ADDR_W] != r_rdPtr[c_ADDR_W]) &&
                       (r_wrPtr[c_ADDR_W-1:0] == r_rdPtr[c_ADDR_W-1:0]);
    assign notEmpty  = (r_wrPtr != r_rdPtr);
    assign occupancy = r_wrPtr - r_rdPtr;
    assign deqData   = r_mem[r_rdPtr[c_ADDR_W-1:0]];
    assign w_push    = enq && !full;
    assign w_pop     = deq && notEmpty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr[c_ADDR_W-1:0]] <= enqData;
    end

endmodule

`default_nettype wire

// File: rtl/qa_shim_tx_credit.sv
//------------------------------------------------------------------------------
// Module : qa_shim_tx_credit
// Brief  : CCI Tx shim buffering C0/C1 requests with read-credit limiting.
//          Optional stats counters: QA_SHIM_TX_CREDIT_STATS_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module qa_shim_tx_credit
    import qa_driver_types::*;
#(
    parameter int CCI_DATA_WIDTH   = QA_CCI_DATA_WIDTH,
    parameter int CCI_TX_HDR_WIDTH = QA_CCI_TX_HDR_WIDTH,
    parameter int BUF_DEPTH        = 16,
    parameter int ALMFULL_SLACK    = 4,
    parameter int MAX_RD_INFLIGHT  = 64
) (
    input  wire logic          clk,
    input  wire logic          reset,
    qa_shim_tx_credit_if.slave bus
);
    localparam int c_PTR_W  = $clog2(BUF_DEPTH) + 1;
    localparam int c_CRED_W = $clog2(MAX_RD_INFLIGHT + 1);
    localparam logic [c_PTR_W-1:0]  c_ALMFULL_LVL = c_PTR_W'(BUF_DEPTH - ALMFULL_SLACK);
    localparam logic [c_CRED_W-1:0] c_CRED_MAX    = c_CRED_W'(MAX_RD_INFLIGHT);
    localparam int c_C1_W   = $bits(t_qa_c1_tx_entry);

    logic [CCI_TX_HDR_WIDTH-1:0] w_c0Head;
    logic                        w_c0NotEmpty, w_c0Full, w_c0Push, w_c0Issue;
    logic [c_PTR_W-1:0]          w_c0Occ, w_c0OccNext;
    t_qa_c1_tx_entry             w_c1EnqEntry, w_c1Head;
    logic                        w_c1Req, w_c1NotEmpty, w_c1Full, w_c1Push, w_c1Issue;
    logic [c_PTR_W-1:0]          w_c1Occ, w_c1OccNext;
    logic                        w_credStall;

    logic [CCI_TX_HDR_WIDTH-1:0] r_c0Hdr, r_c1Hdr;
    logic [CCI_DATA_WIDTH-1:0]   r_c1Data;
    logic                        r_c0RdValid, r_c1WrValid, r_c1IrValid;
    logic                        r_c0AlmFull, r_c1AlmFull;
    logic [c_CRED_W-1:0]         r_inflight;
    logic [2:0]                  r_err;

    qa_shim_fifo #(.WIDTH(CCI_TX_HDR_WIDTH), .DEPTH(BUF_DEPTH)) u_c0Fifo (
        .clk(clk), .reset(reset),
        .enq(bus.afu_C0TxRdValid), .enqData(bus.afu_C0TxHdr),
        .deq(w_c0Issue), .deqData(w_c0Head),
        .notEmpty(w_c0NotEmpty), .full(w_c0Full), .occupancy(w_c0Occ)
    );

    qa_shim_fifo #(.WIDTH(c_C1_W), .DEPTH(BUF_DEPTH)) u_c1Fifo (
        .clk(clk), .reset(reset),
        .enq(w_c1Req), .enqData(w_c1EnqEntry),
        .deq(w_c1Issue), .deqData(w_c1Head),
        .notEmpty(w_c1NotEmpty), .full(w_c1Full), .occupancy(w_c1Occ)
    );

    // A simultaneous Wr+Ir is stored as a write; the collision is only flagged.
    always_comb begin
        w_c1EnqEntry      = '0;
        w_c1EnqEntry.kind = bus.afu_C1TxWrValid ? QA_C1_WR : QA_C1_IR;
        w_c1EnqEntry.hdr  = bus.afu_C1TxHdr;
        w_c1EnqEntry.data = bus.afu_C1TxData;
    end

    assign w_c1Req     = bus.afu_C1TxWrValid || bus.afu_C1TxIrValid;
    assign w_c0Push    = bus.afu_C0TxRdValid && !w_c0Full;
    assign w_c1Push    = w_c1Req && !w_c1Full;
    assign w_c0Issue   = w_c0NotEmpty && !bus.qlp_C0TxAlmFull && (r_inflight < c_CRED_MAX);
    assign w_c1Issue   = w_c1NotEmpty && !bus.qlp_C1TxAlmFull;
    assign w_credStall = w_c0NotEmpty && !bus.qlp_C0TxAlmFull && (r_inflight >= c_CRED_MAX);
    assign w_c0OccNext = w_c0Occ + c_PTR_W'(w_c0Push) - c_PTR_W'(w_c0Issue);
    assign w_c1OccNext = w_c1Occ + c_PTR_W'(w_c1Push) - c_PTR_W'(w_c1Issue);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_c0Hdr     <= '0;
            r_c1Hdr     <= '0;
            r_c1Data    <= '0;
            r_c0RdValid <= 1'b0;
            r_c1WrValid <= 1'b0;
            r_c1IrValid <= 1'b0;
            r_c0AlmFull <= 1'b1;
            r_c1AlmFull <= 1'b1;
            r_inflight  <= '0;
            r_err       <= '0;
        end else begin
            r_c0RdValid <= w_c0Issue;
            r_c1WrValid <= w_c1Issue && (w_c1Head.kind == QA_C1_WR);
            r_c1IrValid <= w_c1Issue && (w_c1Head.kind == QA_C1_IR);
            if (w_c0Issue) r_c0Hdr <= w_c0Head;
            if (w_c1Issue) begin
                r_c1Hdr  <= w_c1Head.hdr;
                r_c1Data <= w_c1Head.data;
            end
            r_c0AlmFull <= (w_c0OccNext >= c_ALMFULL_LVL);
            r_c1AlmFull <= (w_c1OccNext >= c_ALMFULL_LVL);

            if (w_c0Issue && !bus.qlp_C0RxRdValid) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_c0Issue && bus.qlp_C0RxRdValid) begin
                if (r_inflight == '0) r_err[ERR_CREDIT_UNF] <= 1'b1;
                else                  r_inflight <= r_inflight - 1'b1;
            end

            if ((bus.afu_C0TxRdValid && w_c0Full) || (w_c1Req && w_c1Full))
                r_err[ERR_FIFO_OVF] <= 1'b1;
            if (bus.afu_C1TxWrValid && bus.afu_C1TxIrValid)
                r_err[ERR_C1_COLLIDE] <= 1'b1;
        end
    end

    assign bus.qlp_C0TxHdr     = r_c0Hdr;
    assign bus.qlp_C0TxRdValid = r_c0RdValid;
    assign bus.qlp_C1TxHdr     = r_c1Hdr;
    assign bus.qlp_C1TxData    = r_c1Data;
    assign bus.qlp_C1TxWrValid = r_c1WrValid;
    assign bus.qlp_C1TxIrValid = r_c1IrValid;
    assign bus.afu_C0TxAlmFull = r_c0AlmFull;
    assign bus.afu_C1TxAlmFull = r_c1AlmFull;
    assign bus.err_sticky      = r_err;

`ifdef QA_SHIM_TX_CREDIT_STATS_EN
    logic [31:0] r_statRd, r_statWr, r_statStall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_statRd    <= '0;
            r_statWr    <= '0;
            r_statStall <= '0;
        end else begin
            if (w_c0Issue && (r_statRd != '1)) r_statRd <= r_statRd + 1'b1;
            if (w_c1Issue && (w_c1Head.kind == QA_C1_WR) && (r_statWr != '1))
                r_statWr <= r_statWr + 1'b1;
            if (w_credStall && (r_statStall != '1)) r_statStall <= r_statStall + 1'b1;
        end
    end

    assign bus.stat_rd_issued           = r_statRd;
    assign bus.stat_wr_issued           = r_statWr;
    assign bus.stat_credit_stall_cycles = r_statStall;
`else
    logic w_unusedStall;
    assign w_unusedStall = w_credStall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qa_shim_tx_credit.sv
//------------------------------------------------------------------------------
// Module : tb_qa_shim_tx_credit
// Brief  : Directed self-checking bench for the QA Tx credit shim.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_qa_shim_tx_credit;
    import qa_driver_types::*;

    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nPass   = 0;

    always #5 clk = ~clk;

    qa_shim_tx_credit_if #(.CCI_DATA_WIDTH(512), .CCI_TX_HDR_WIDTH(61)) bus ();

    qa_shim_tx_credit #(
        .CCI_DATA_WIDTH(512), .CCI_TX_HDR_WIDTH(61), .BUF_DEPTH(16),
        .ALMFULL_SLACK(4), .MAX_RD_INFLIGHT(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        reset               = 1'b1;
        bus.afu_C0TxHdr     = '0;
        bus.afu_C0TxRdValid = 1'b0;
        bus.afu_C1TxHdr     = '0;
        bus.afu_C1TxData    = '0;
        bus.afu_C1TxWrValid = 1'b0;
        bus.afu_C1TxIrValid = 1'b0;
        bus.qlp_C0TxAlmFull = 1'b0;
        bus.qlp_C1TxAlmFull = 1'b0;
        bus.qlp_C0RxRdValid = 1'b0;
        tick();
        tick();
        chk("rstC0AlmFull", 64'(bus.afu_C0TxAlmFull), 64'd1);
        chk("rstC1AlmFull", 64'(bus.afu_C1TxAlmFull), 64'd1);
        chk("rstValids", 64'({bus.qlp_C0TxRdValid, bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'd0);
        chk("rstErr", 64'(bus.err_sticky), 64'd0);

        reset = 1'b0;
        tick();
        chk("idleC0AlmFull", 64'(bus.afu_C0TxAlmFull), 64'd0);
        chk("idleC1AlmFull", 64'(bus.afu_C1TxAlmFull), 64'd0);
        chk("idleValids", 64'({bus.qlp_C0TxRdValid, bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'd0);
        chk("idleErr", 64'(bus.err_sticky), 64'd0);

        // Fill the C0 FIFO with QLP held off; threshold is 16-4 = 12 entries.
        bus.qlp_C0TxAlmFull = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            bus.afu_C0TxHdr     = 61'(i);
            bus.afu_C0TxRdValid = 1'b1;
            tick();
            if (i == 11) chk("almFullAt11", 64'(bus.afu_C0TxAlmFull), 64'd0);
            if (i == 12) chk("almFullAt12", 64'(bus.afu_C0TxAlmFull), 64'd1);
            if (i == 16) chk("noOvfAt16", 64'(bus.err_sticky), 64'd0);
        end
        bus.afu_C0TxRdValid = 1'b0;
        chk("ovfErr", 64'(bus.err_sticky), 64'b001);
        chk("heldNoIssue", 64'(bus.qlp_C0TxRdValid), 64'd0);

        // Release QLP: credit limit of 4 lets exactly hdr 1..4 through.
        bus.qlp_C0TxAlmFull = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("issue%0dValid", i), 64'(bus.qlp_C0TxRdValid), 64'd1);
            chk($sformatf("issue%0dHdr", i), 64'(bus.qlp_C0TxHdr), 64'(i));
        end
        tick();
        chk("creditStall1", 64'(bus.qlp_C0TxRdValid), 64'd0);
        tick();
        chk("creditStall2", 64'(bus.qlp_C0TxRdValid), 64'd0);

        bus.qlp_C0RxRdValid = 1'b1;
        tick();
        bus.qlp_C0RxRdValid = 1'b0;
        chk("rspNoIssueYet", 64'(bus.qlp_C0TxRdValid), 64'd0);
        tick();
        chk("issue5Valid", 64'(bus.qlp_C0TxRdValid), 64'd1);
        chk("issue5Hdr", 64'(bus.qlp_C0TxHdr), 64'd5);

        // Bring count to 3, then issue and response together keep it at 3.
        bus.qlp_C0RxRdValid = 1'b1;
        tick();
        chk("dec4to3NoIssue", 64'(bus.qlp_C0TxRdValid), 64'd0);
        tick();
        bus.qlp_C0RxRdValid = 1'b0;
        chk("simulIssue6", 64'(bus.qlp_C0TxHdr), 64'd6);
        chk("simulValid6", 64'(bus.qlp_C0TxRdValid), 64'd1);
        tick();
        chk("issue7Valid", 64'(bus.qlp_C0TxRdValid), 64'd1);
        chk("issue7Hdr", 64'(bus.qlp_C0TxHdr), 64'd7);
        tick();
        chk("stallAfter7", 64'(bus.qlp_C0TxRdValid), 64'd0);

        // Drain all 4 credits with QLP held, then one extra response underflows.
        bus.qlp_C0TxAlmFull = 1'b1;
        bus.qlp_C0RxRdValid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drainNoUnf", 64'(bus.err_sticky), 64'b001);
        tick();
        bus.qlp_C0RxRdValid = 1'b0;
        chk("unfErr", 64'(bus.err_sticky), 64'b011);
        bus.qlp_C0TxAlmFull = 1'b0;
        tick();
        chk("afterUnfIssue", 64'(bus.qlp_C0TxRdValid), 64'd1);
        chk("afterUnfHdr", 64'(bus.qlp_C0TxHdr), 64'd8);
        chk("almFullDrop", 64'(bus.afu_C0TxAlmFull), 64'd0);
        bus.qlp_C0TxAlmFull = 1'b1;

        // C1 collision: stored and issued as a write, error bit 2 set.
        bus.afu_C1TxHdr     = 61'h33;
        bus.afu_C1TxData    = 512'hA5;
        bus.afu_C1TxWrValid = 1'b1;
        bus.afu_C1TxIrValid = 1'b1;
        tick();
        bus.afu_C1TxWrValid = 1'b0;
        bus.afu_C1TxIrValid = 1'b0;
        chk("c1NotYet", 64'({bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'd0);
        tick();
        chk("c1CollWrIr", 64'({bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'b10);
        chk("c1CollData", bus.qlp_C1TxData[63:0], 64'hA5);
        chk("c1CollDataHi", 64'(|bus.qlp_C1TxData[511:64]), 64'd0);
        chk("c1CollHdr", 64'(bus.qlp_C1TxHdr), 64'h33);
        chk("collErr", 64'(bus.err_sticky), 64'b111);

        bus.afu_C1TxHdr     = 61'h44;
        bus.afu_C1TxIrValid = 1'b1;
        tick();
        bus.afu_C1TxIrValid = 1'b0;
        chk("c1Idle", 64'({bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'd0);
        tick();
        chk("c1IrOnly", 64'({bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'b01);
        chk("c1IrHdr", 64'(bus.qlp_C1TxHdr), 64'h44);
        tick();
        chk("c1Quiet", 64'({bus.qlp_C1TxWrValid, bus.qlp_C1TxIrValid}), 64'd0);

        // Reset flushes state and clears sticky errors.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.qlp_C0TxAlmFull = 1'b0;
        tick();
        chk("rst2Err", 64'(bus.err_sticky), 64'd0);
        tick();
        chk("rst2Flushed", 64'(bus.qlp_C0TxRdValid), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
